piano_keypad_poly: RTL and testbench

// - Polyphonic successor of the single-note keypad mapper: turns keypad press/release events into NUM_VOICES

---
 rtl/piano_pkg.sv | 46 ++++
 rtl/piano_key_decode.sv | 32 +++
 rtl/piano_keypad_poly.sv | 164 ++++++++++++++++
 tb/tb_piano_keypad_poly.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared note, keycode and command definitions for the keypad-to-voice mappers.
package piano_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned KC_W   = 5;
  localparam int unsigned OCT_W  = 4;

  typedef enum logic [NOTE_W-1:0] {
    REST = 4'd0,
    C    = 4'd1,
    CS   = 4'd2,
    D    = 4'd3,
    DS   = 4'd4,
    E    = 4'd5,
    F    = 4'd6,
    FS   = 4'd7,
    G    = 4'd8,
    GS   = 4'd9,
    A    = 4'd10,
    AS   = 4'd11,
    B    = 4'd12
  } note_e;

  localparam logic [KC_W-1:0] KC_C      = 5'd4;
  localparam logic [KC_W-1:0] KC_CS     = 5'd8;
  localparam logic [KC_W-1:0] KC_D      = 5'd5;
  localparam logic [KC_W-1:0] KC_DS     = 5'd9;
  localparam logic [KC_W-1:0] KC_E      = 5'd6;
  localparam logic [KC_W-1:0] KC_F      = 5'd7;
  localparam logic [KC_W-1:0] KC_FS     = 5'd11;
  localparam logic [KC_W-1:0] KC_G      = 5'd12;
  localparam logic [KC_W-1:0] KC_GS     = 5'd16;
  localparam logic [KC_W-1:0] KC_A      = 5'd13;
  localparam logic [KC_W-1:0] KC_AS     = 5'd17;
  localparam logic [KC_W-1:0] KC_B      = 5'd14;
  localparam logic [KC_W-1:0] KC_OCT_UP = 5'd15;
  localparam logic [KC_W-1:0] KC_OCT_DN = 5'd19;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_NOTE   = 2'd1,
    CMD_OCT_UP = 2'd2,
    CMD_OCT_DN = 2'd3
  } cmd_e;

endpackage

// File: rtl/piano_key_decode.sv
// Combinational keycode decoder: scanner index -> command and note code.
module piano_key_decode
  import piano_pkg::*;
(
  input  logic [4:0] keycode,
  output logic [1:0] cmd_c,
  output logic [3:0] note_c
);

  always_comb begin
    cmd_c  = CMD_NONE;
    note_c = REST;
    case (keycode)
      KC_C:      begin cmd_c = CMD_NOTE; note_c = C;  end
      KC_CS:     begin cmd_c = CMD_NOTE; note_c = CS; end
      KC_D:      begin cmd_c = CMD_NOTE; note_c = D;  end
      KC_DS:     begin cmd_c = CMD_NOTE; note_c = DS; end
      KC_E:      begin cmd_c = CMD_NOTE; note_c = E;  end
      KC_F:      begin cmd_c = CMD_NOTE; note_c = F;  end
      KC_FS:     begin cmd_c = CMD_NOTE; note_c = FS; end
      KC_G:      begin cmd_c = CMD_NOTE; note_c = G;  end
      KC_GS:     begin cmd_c = CMD_NOTE; note_c = GS; end
      KC_A:      begin cmd_c = CMD_NOTE; note_c = A;  end
      KC_AS:     begin cmd_c = CMD_NOTE; note_c = AS; end
      KC_B:      begin cmd_c = CMD_NOTE; note_c = B;  end
      KC_OCT_UP: cmd_c = CMD_OCT_UP;
      KC_OCT_DN: cmd_c = CMD_OCT_DN;
      default:   ;
    endcase
  end

endmodule

// File: rtl/piano_keypad_poly.sv
// Polyphonic keypad mapper: allocates voice slots with oldest-voice stealing,
// tracks the octave, and emits per-slot retrigger pulses.
module piano_keypad_poly
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned OCT_MIN    = 0,
  parameter int unsigned OCT_MAX    = 9,
  parameter int unsigned OCT_INIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic                    key_press,
  input  logic [4:0]              keycode,
  input  logic                    panic,
  output logic [3:0]              octave,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [4*NUM_VOICES-1:0] voice_note,
  output logic [4*NUM_VOICES-1:0] voice_octave,
  output logic [NUM_VOICES-1:0]   voice_trig
);

  localparam int unsigned RANK_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                  ready_q, ready_d;
  logic [OCT_W-1:0]      octave_q, octave_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES];
  logic [OCT_W-1:0]      voct_q [NUM_VOICES];
  logic [OCT_W-1:0]      voct_d [NUM_VOICES];
  logic [KC_W-1:0]       kc_q   [NUM_VOICES];
  logic [KC_W-1:0]       kc_d   [NUM_VOICES];
  logic [RANK_W-1:0]     rank_q [NUM_VOICES];
  logic [RANK_W-1:0]     rank_d [NUM_VOICES];

  logic [1:0]        cmd_raw;
  cmd_e              cmd;
  logic [NOTE_W-1:0] dec_note;

  piano_key_decode u_decode (
    .keycode (keycode),
    .cmd_c   (cmd_raw),
    .note_c  (dec_note)
  );

  assign cmd = cmd_e'(cmd_raw);

  logic              hit;
  logic [RANK_W-1:0] hit_idx;
  logic              free_found;
  logic [RANK_W-1:0] free_idx;
  logic [RANK_W-1:0] oldest_idx;
  logic [RANK_W-1:0] alloc_idx;

  // Held-key match, lowest free slot and least-recently-allocated slot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (active_q[i] && (kc_q[i] == keycode) && !hit) begin
        hit     = 1'b1;
        hit_idx = RANK_W'(i);
      end
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RANK_W'(i);
      end
      if (rank_q[i] == RANK_W'(NUM_VOICES - 1)) begin
        oldest_idx = RANK_W'(i);
      end
    end
  end

  assign alloc_idx = free_found ? free_idx : oldest_idx;

  always_comb begin
    ready_d  = 1'b1;
    octave_d = octave_q;
    active_d = active_q;
    trig_d   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      note_d[i] = note_q[i];
      voct_d[i] = voct_q[i];
      kc_d[i]   = kc_q[i];
      rank_d[i] = rank_q[i];
    end

    if (panic) begin
      active_d = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_d[i] = REST;
      end
    end else if (key_valid && ready_q) begin
      if (key_press) begin
        case (cmd)
          CMD_OCT_UP: if (octave_q < OCT_W'(OCT_MAX)) octave_d = octave_q + 4'd1;
          CMD_OCT_DN: if (octave_q > OCT_W'(OCT_MIN)) octave_d = octave_q - 4'd1;
          CMD_NOTE: begin
            if (!hit) begin
              active_d[alloc_idx] = 1'b1;
              note_d[alloc_idx]   = dec_note;
              voct_d[alloc_idx]   = octave_q;
              kc_d[alloc_idx]     = keycode;
              trig_d[alloc_idx]   = 1'b1;
              // Younger slots age by one; the allocated slot becomes the newest.
              for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (rank_q[i] < rank_q[alloc_idx]) rank_d[i] = rank_q[i] + 1'b1;
              end
              rank_d[alloc_idx] = '0;
            end
          end
          default: ;
        endcase
      end else if (hit) begin
        active_d[hit_idx] = 1'b0;
        note_d[hit_idx]   = REST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      octave_q <= OCT_W'(OCT_INIT);
      active_q <= '0;
      trig_q   <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= REST;
        voct_q[i] <= '0;
        kc_q[i]   <= '0;
        rank_q[i] <= RANK_W'(i);
      end
    end else begin
      ready_q  <= ready_d;
      octave_q <= octave_d;
      active_q <= active_d;
      trig_q   <= trig_d;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= note_d[i];
        voct_q[i] <= voct_d[i];
        kc_q[i]   <= kc_d[i];
        rank_q[i] <= rank_d[i];
      end
    end
  end

  assign key_ready    = ready_q;
  assign octave       = octave_q;
  assign voice_active = active_q;
  assign voice_trig   = trig_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_out
    assign voice_note[4*g +: 4]   = note_q[g];
    assign voice_octave[4*g +: 4] = voct_q[g];
  end

endmodule

// File: tb/tb_piano_keypad_poly.sv
// Directed scoreboard bench for piano_keypad_poly with NUM_VOICES=4, octave range 0..9.
module tb_piano_keypad_poly;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic        key_press;
  logic [4:0]  keycode;
  logic        panic;
  logic [3:0]  octave;
  logic [3:0]  voice_active;
  logic [15:0] voice_note;
  logic [15:0] voice_octave;
  logic [3:0]  voice_trig;

  piano_keypad_poly #(
    .NUM_VOICES (4),
    .OCT_MIN    (0),
    .OCT_MAX    (9),
    .OCT_INIT   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_press    (key_press),
    .keycode      (keycode),
    .panic        (panic),
    .octave       (octave),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .voice_octave (voice_octave),
    .voice_trig   (voice_trig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [3:0]  oct;
    logic [3:0]  act;
    logic [15:0] note;
    logic [15:0] voct;
    logic [3:0]  trig;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    x = sb.pop_front();
    check({tag, ".ready"}, 16'(key_ready),    16'(x.ready));
    check({tag, ".oct"},   16'(octave),       16'(x.oct));
    check({tag, ".act"},   16'(voice_active), 16'(x.act));
    check({tag, ".note"},  voice_note,        x.note);
    check({tag, ".voct"},  voice_octave,      x.voct);
    check({tag, ".trig"},  16'(voice_trig),   16'(x.trig));
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then compare.
  task automatic step(input string tag, input logic r, input logic v, input logic p,
                      input logic [4:0] kc, input logic pn);
    rst       = r;
    key_valid = v;
    key_press = p;
    keycode   = kc;
    panic     = pn;
    sb.push_back(e);
    e.trig = 4'b0000;
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_press = 1'b0; keycode = 5'd0; panic = 1'b0;
    e = '{ready: 1'b0, oct: 4'd4, act: 4'h0, note: 16'h0000, voct: 16'h0000, trig: 4'h0};

    step("reset0", 1, 0, 0, 5'd0, 0);
    step("reset_press", 1, 1, 1, 5'd4, 0);
    rst = 1'b0;
    check("ready_low_after_rst", 16'(key_ready), 16'h0000);
    e.ready = 1'b1;
    step("press_not_ready", 0, 1, 1, 5'd4, 0);

    // C, E, G into slots 0..2
    e.act = 4'b0001; e.note = 16'h0001; e.voct = 16'h0004; e.trig = 4'b0001;
    step("press_C", 0, 1, 1, 5'd4, 0);
    e.act = 4'b0011; e.note = 16'h0051; e.voct = 16'h0044; e.trig = 4'b0010;
    step("press_E", 0, 1, 1, 5'd6, 0);
    e.act = 4'b0111; e.note = 16'h0851; e.voct = 16'h0444; e.trig = 4'b0100;
    step("press_G", 0, 1, 1, 5'd12, 0);
    step("idle", 0, 0, 0, 5'd0, 0);
    step("no_valid", 0, 0, 1, 5'd7, 0);

    for (int k = 1; k <= 6; k++) begin
      e.oct = (4 + k > 9) ? 4'd9 : 4'(4 + k);
      step("oct_up", 0, 1, 1, 5'd15, 0);
    end
    step("oct_up_release", 0, 1, 0, 5'd15, 0);

    e.act = 4'b1111; e.note = 16'h6851; e.voct = 16'h9444; e.trig = 4'b1000;
    step("press_F_oct9", 0, 1, 1, 5'd7, 0);

    for (int k = 1; k <= 12; k++) begin
      e.oct = (k >= 9) ? 4'd0 : 4'(9 - k);
      step("oct_dn", 0, 1, 1, 5'd19, 0);
    end

    // Steal the oldest slot, twice, to follow the age order
    e.note = 16'h6853; e.voct = 16'h9440; e.trig = 4'b0001;
    step("steal_slot0_D", 0, 1, 1, 5'd5, 0);
    step("release_stolen_C", 0, 1, 0, 5'd4, 0);
    e.note = 16'h68C3; e.voct = 16'h9400; e.trig = 4'b0010;
    step("steal_slot1_B", 0, 1, 1, 5'd14, 0);

    e.act = 4'b1011; e.note = 16'h60C3;
    step("release_G", 0, 1, 0, 5'd12, 0);
    e.act = 4'b1111; e.note = 16'h61C3; e.voct = 16'h9000; e.trig = 4'b0100;
    step("refill_slot2_C", 0, 1, 1, 5'd4, 0);
    e.note = 16'hA1C3; e.voct = 16'h0000; e.trig = 4'b1000;
    step("steal_slot3_A", 0, 1, 1, 5'd13, 0);

    step("press_held_C", 0, 1, 1, 5'd4, 0);
    e.act = 4'b1011; e.note = 16'hA0C3;
    step("release_C", 0, 1, 0, 5'd4, 0);
    step("release_unheld", 0, 1, 0, 5'd16, 0);
    step("press_code0", 0, 1, 1, 5'd0, 0);
    step("press_code31", 0, 1, 1, 5'd31, 0);

    e.oct = 4'd1;
    step("oct_up_to1", 0, 1, 1, 5'd15, 0);
    e.act = 4'b0000; e.note = 16'h0000;
    step("panic_with_press", 0, 1, 1, 5'd5, 1);
    e.act = 4'b0001; e.note = 16'h0004; e.voct = 16'h0001; e.trig = 4'b0001;
    step("press_DS_after_panic", 0, 1, 1, 5'd9, 0);

    e = '{ready: 1'b0, oct: 4'd4, act: 4'h0, note: 16'h0000, voct: 16'h0000, trig: 4'h0};
    step("rst_and_panic", 1, 1, 1, 5'd6, 1);
    e.ready = 1'b1;
    step("post_rst_not_ready", 0, 1, 1, 5'd6, 0);
    e.act = 4'b0001; e.note = 16'h0005; e.voct = 16'h0004; e.trig = 4'b0001;
    step("press_E_after_rst", 0, 1, 1, 5'd6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
